// File: rtl/fp4_mul_rr_scheduler.sv
// Round-robin scheduler sharing one combinational FP4 E2M1 multiplier between NUM_REQ lanes.
// Optional per-lane grant counters are enabled with FP4_SCHED_STATS_EN.
module fp4_mul_rr_scheduler #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*4-1:0] req_a,
  input  logic [NUM_REQ*4-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_sat,
  output logic [3:0]           mul_a,
  output logic [3:0]           mul_b,
  output logic                 mul_sat,
  input  logic [3:0]           mul_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_result
`ifdef FP4_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_grant_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RESP  = 2'b01,
    ISSUE = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        iss_a_q, iss_a_d, iss_b_q, iss_b_d;
  logic              iss_sat_q, iss_sat_d;
  logic [ID_W-1:0]   iss_id_q, iss_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [3:0]        rsp_result_q, rsp_result_d;

  logic              iss_valid, rsp_adv, iss_adv, hs;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W:0]     scan;
  logic [NUM_REQ-1:0] grant;

  assign iss_valid  = (state_q == ISSUE) || (state_q == FULL);
  assign rsp_valid  = (state_q == RESP)  || (state_q == FULL);
  assign rsp_adv    = !rsp_valid || rsp_ready;
  assign iss_adv    = !iss_valid || rsp_adv;
  assign hs         = gnt_any && iss_adv && !rst;
  assign mul_a      = iss_a_q;
  assign mul_b      = iss_b_q;
  assign mul_sat    = iss_sat_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

  // Search upward from rr_ptr with wrap; the first valid lane wins.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && req_valid[scan[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = scan[ID_W-1:0];
      end
    end
    grant[gnt_id] = gnt_any;
    req_ready     = (iss_adv && !rst) ? grant : '0;
  end

  always_comb begin
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_sat_d    = iss_sat_q;
    iss_id_d     = iss_id_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    if (hs) begin
      iss_a_d   = req_a[4*gnt_id +: 4];
      iss_b_d   = req_b[4*gnt_id +: 4];
      iss_sat_d = req_sat[gnt_id];
      iss_id_d  = gnt_id;
      rr_ptr_d  = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end else if (iss_adv) begin
      // Idle issue slot presents zero operands so the multiplier outputs +0.
      iss_a_d   = '0;
      iss_b_d   = '0;
      iss_sat_d = 1'b0;
      iss_id_d  = '0;
    end
    if (rsp_adv) begin
      rsp_id_d     = iss_id_q;
      rsp_result_d = mul_result;
    end
  end

  always_comb begin
    state_d = state_q;
    case ({hs ? 1'b1 : (iss_adv ? 1'b0 : iss_valid), rsp_adv ? iss_valid : rsp_valid})
      2'b00:   state_d = EMPTY;
      2'b01:   state_d = RESP;
      2'b10:   state_d = ISSUE;
      default: state_d = FULL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_sat_q    <= 1'b0;
      iss_id_q     <= '0;
      rr_ptr_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_sat_q    <= iss_sat_d;
      iss_id_q     <= iss_id_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

`ifdef FP4_SCHED_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i] && grant_cnt_q[i] != 16'hFFFF)
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grant_cnt[16*i +: 16] = grant_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fp4_mul_rr_scheduler.sv
// Directed self-checking bench for fp4_mul_rr_scheduler; a behavioural E2M1 multiplier stub
// closes the mul_* loop. Define FP4_SCHED_STATS_EN to also check the grant counters.
module tb_fp4_mul_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*4-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]   req_sat;
  logic [3:0]           mul_a, mul_b, mul_result;
  logic                 mul_sat;
  logic                 rsp_valid, rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [3:0]           rsp_result;
`ifdef FP4_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0] stat_grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fp4_mul_rr_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sat(req_sat),
    .mul_a(mul_a), .mul_b(mul_b), .mul_sat(mul_sat), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
`ifdef FP4_SCHED_STATS_EN
    , .stat_grant_cnt(stat_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // E2M1 magnitude in units of 0.5
  function automatic int halves(input logic [2:0] m);
    case (m)
      3'd0: return 0;  3'd1: return 1;  3'd2: return 2;  3'd3: return 3;
      3'd4: return 4;  3'd5: return 6;  3'd6: return 8;  default: return 12;
    endcase
  endfunction

  // Round to nearest magnitude (ties to the smaller one), clamp at 6.0
  function automatic logic [3:0] fp4_mul(input logic [3:0] a, input logic [3:0] b);
    int p, d, bestd;
    logic [2:0] best;
    p = halves(a[2:0]) * halves(b[2:0]);
    best = 3'd0;
    bestd = p;
    for (int c = 1; c < 8; c++) begin
      d = p - 2 * halves(3'(c));
      if (d < 0) d = -d;
      if (d < bestd) begin bestd = d; best = 3'(c); end
    end
    return {a[3] ^ b[3], best};
  endfunction

  always_comb mul_result = fp4_mul(mul_a, mul_b);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic set_lane(input int i, input logic [3:0] a, input logic [3:0] b, input logic s);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
    req_sat[i]      = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sat = '0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_result !== 4'h0) begin errors++; $display("[TB] FAIL reset_rsp_result got %h exp 0", rsp_result); end
    checks++; if ({mul_a, mul_b, mul_sat} !== 9'd0) begin errors++; $display("[TB] FAIL reset_mul got %h/%h/%b exp 0/0/0", mul_a, mul_b, mul_sat); end
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    set_lane(0, 4'b0010, 4'b0011, 1'b0);
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got %b exp 0001", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rv_n got %b exp 0", rsp_valid); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if ({mul_a, mul_b, mul_sat} !== {4'b0010, 4'b0011, 1'b0}) begin errors++; $display("[TB] FAIL single_issue got %h/%h/%b exp 2/3/0", mul_a, mul_b, mul_sat); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rv_n1 got %b exp 0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd0, 4'b0011}) begin errors++; $display("[TB] FAIL single_rsp got v%b id%0d r%h exp v1 id0 r3", rsp_valid, rsp_id, rsp_result); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %b exp 0", rsp_valid); end
    checks++; if (mul_a !== 4'h0) begin errors++; $display("[TB] FAIL single_idle_mul got %h exp 0", mul_a); end
  endtask

  task automatic test_all_lanes();
    logic [3:0] exp_res [4] = '{4'h2, 4'h4, 4'h5, 4'h6};
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    do_reset();
`ifdef FP4_SCHED_STATS_EN
    checks++; if (stat_grant_cnt !== '0) begin errors++; $display("[TB] FAIL stats_clear got %h exp 0", stat_grant_cnt); end
`endif
    for (int i = 0; i < 4; i++) set_lane(i, 4'(i + 1), 4'b0100, 1'b0);
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000; #1;
      exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL all_ready c%0d got %b exp %b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== (c >= 2 && c < 10)) begin errors++; $display("[TB] FAIL all_rv c%0d got %b", c, rsp_valid); end
      if (c >= 2 && c < 10) begin
        exp_id = 2'((c - 2) % 4);
        checks++; if ({rsp_id, rsp_result} !== {exp_id, exp_res[exp_id]}) begin errors++; $display("[TB] FAIL all_rsp c%0d got id%0d r%h exp id%0d r%h", c, rsp_id, rsp_result, exp_id, exp_res[exp_id]); end
      end
      @(negedge clk);
    end
`ifdef FP4_SCHED_STATS_EN
    checks++; if (stat_grant_cnt !== {16'd2, 16'd2, 16'd2, 16'd2}) begin errors++; $display("[TB] FAIL stats_count got %h exp 4x0002", stat_grant_cnt); end
`endif
  endtask

  task automatic test_rr_wrap();
    logic [3:0] vld [7] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] rdy [7] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic       rv  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] id  [7] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0};
    logic [3:0] res [7] = '{4'h0, 4'h0, 4'h2, 4'h7, 4'h2, 4'h7, 4'h0};
    do_reset();
    set_lane(1, 4'b0010, 4'b0010, 1'b0);
    set_lane(3, 4'b0100, 4'b0101, 1'b0);
    for (int c = 0; c < 7; c++) begin
      req_valid = vld[c]; #1;
      checks++; if (req_ready !== rdy[c]) begin errors++; $display("[TB] FAIL rr_ready c%0d got %b exp %b", c, req_ready, rdy[c]); end
      checks++; if (rsp_valid !== rv[c]) begin errors++; $display("[TB] FAIL rr_rv c%0d got %b exp %b", c, rsp_valid, rv[c]); end
      if (rv[c]) begin
        checks++; if ({rsp_id, rsp_result} !== {id[c], res[c]}) begin errors++; $display("[TB] FAIL rr_rsp c%0d got id%0d r%h exp id%0d r%h", c, rsp_id, rsp_result, id[c], res[c]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [3:0] rdy [10] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic       rv  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] id  [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_res [4] = '{4'h2, 4'h4, 4'h5, 4'h6};
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 4'(i + 1), 4'b0100, 1'b0);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 7) ? 4'b1111 : 4'b0000;
      rsp_ready = (c >= 5); #1;
      checks++; if (req_ready !== rdy[c]) begin errors++; $display("[TB] FAIL stall_ready c%0d got %b exp %b", c, req_ready, rdy[c]); end
      checks++; if (rsp_valid !== rv[c]) begin errors++; $display("[TB] FAIL stall_rv c%0d got %b exp %b", c, rsp_valid, rv[c]); end
      if (rv[c]) begin
        checks++; if ({rsp_id, rsp_result} !== {id[c], exp_res[id[c]]}) begin errors++; $display("[TB] FAIL stall_rsp c%0d got id%0d r%h exp id%0d r%h", c, rsp_id, rsp_result, id[c], exp_res[id[c]]); end
      end
      if (c >= 2 && c <= 4) begin
        checks++; if (mul_a !== 4'h2) begin errors++; $display("[TB] FAIL stall_issue_hold c%0d got %h exp 2", c, mul_a); end
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    set_lane(2, 4'b0111, 4'b0111, 1'b1);
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL sat_ready got %b exp 0100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if ({mul_a, mul_b, mul_sat} !== {4'h7, 4'h7, 1'b1}) begin errors++; $display("[TB] FAIL sat_issue got %h/%h/%b exp 7/7/1", mul_a, mul_b, mul_sat); end
    @(negedge clk); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd2, 4'b0111}) begin errors++; $display("[TB] FAIL sat_rsp got v%b id%0d r%h exp v1 id2 r7", rsp_valid, rsp_id, rsp_result); end
    @(negedge clk);
  endtask

  task automatic test_reset_full();
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 4'(i + 1), 4'b0100, 1'b0);
    req_valid = 4'b1111; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if ({rsp_valid, req_ready} !== 5'b1_0000) begin errors++; $display("[TB] FAIL rf_full got v%b rdy%b exp v1 rdy0000", rsp_valid, req_ready); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rf_rst_ready got %b exp 0000", req_ready); end
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_post_rv got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rf_post_grant got %b exp 0001", req_ready); end
    checks++; if (mul_a !== 4'h0) begin errors++; $display("[TB] FAIL rf_post_issue got %h exp 0", mul_a); end
`ifdef FP4_SCHED_STATS_EN
    checks++; if (stat_grant_cnt !== '0) begin errors++; $display("[TB] FAIL rf_stats got %h exp 0", stat_grant_cnt); end
`endif
    @(negedge clk); #1;
    checks++; if ({rsp_valid, req_ready} !== 5'b0_0010) begin errors++; $display("[TB] FAIL rf_second got v%b rdy%b exp v0 rdy0010", rsp_valid, req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd0, 4'h2}) begin errors++; $display("[TB] FAIL rf_first_rsp got v%b id%0d r%h exp v1 id0 r2", rsp_valid, rsp_id, rsp_result); end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sat = '0; rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_all_lanes();
    test_rr_wrap();
    test_stall();
    test_saturate();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
